// File: rtl/skid_buffer.sv
// skid_buffer -- two-entry ready/valid pipeline stage with fully registered
// outputs. Words land in the main register (which drives m_data_o). When
// downstream stalls while upstream is still sending, the in-flight word is
// caught in the skid register. Because s_ready_o is a flop, it can only drop
// one cycle late, and the skid register absorbs that one word.
//
// Parameters:
//   DATA_WIDTH   payload width in bits (default 8)
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset; buffered words are discarded
//   s_valid_i    upstream word valid
//   s_data_i     upstream word
//   s_ready_o    block can accept a word (registered)
//   m_valid_o    downstream word valid (registered)
//   m_data_o     downstream word (registered)
//   m_ready_i    downstream accepts the word
//   stall_cnt_o  saturating count of edges with m_valid_o && !m_ready_i;
//                present only when SKID_BUFFER_STATS_EN is defined
//
// Optional feature macro: SKID_BUFFER_STATS_EN (stall counter and its port).
module skid_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  up_xfer;
  logic                  dn_xfer;

  // Handshakes use the registered flags, so m_ready_i is inert in EMPTY and
  // no upstream transfer can happen in FULL.
  assign up_xfer = s_valid_i && s_ready_q;
  assign dn_xfer = m_valid_q && m_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          main_d  = s_data_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          main_d = s_data_i;
        end else if (up_xfer) begin
          skid_d  = s_data_i;
          state_d = FULL;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Output flags are registered copies of the next state so that every
    // output comes straight from a flop.
    s_ready_d = (state_d != FULL);
    m_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = main_q;

`ifdef SKID_BUFFER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !m_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port s_valid_i, input, 1: upstream word valid.
REQ-005 SHALL have port s_data_i, input, DATA_WIDTH: upstream word.
REQ-006 SHALL have port s_ready_o, output, 1: block can accept a word; driven directly from a flop.
REQ-007 SHALL have port m_valid_o, output, 1: downstream word valid; driven directly from a flop.
REQ-008 SHALL have port m_data_o, output, DATA_WIDTH: downstream word; driven directly from a flop.
REQ-009 SHALL have port m_ready_i, input, 1: downstream accepts the word.
REQ-010 SHALL have port stall_cnt_o, output, 16: saturating stall count; present only per REQ-030.

Function
REQ-011 SHALL perform an upstream transfer on a rising edge with s_valid_i && s_ready_o, and a downstream transfer on a rising edge with m_valid_o && m_ready_i.
REQ-012 SHALL hold a main register (drives m_data_o) and a skid register, with states EMPTY, BUSY (main full) and FULL (main and skid full).
REQ-013 SHALL drive s_ready_o = (state != FULL) and m_valid_o = (state != EMPTY), both as registered values.
REQ-014 SHALL in EMPTY, on an upstream transfer, load main and go to BUSY; otherwise stay.
REQ-015 SHALL in BUSY, with upstream and downstream transfers together, load main with s_data_i and stay in BUSY.
REQ-016 SHALL in BUSY, with only an upstream transfer, load skid with s_data_i, hold main, and go to FULL.
REQ-017 SHALL in BUSY, with only a downstream transfer, go to EMPTY; with neither, hold.
REQ-018 SHALL in FULL, on a downstream transfer, copy skid to main and go to BUSY; otherwise hold. No upstream transfer is possible in FULL.
REQ-019 SHALL have a latency of 1 cycle (word accepted at edge N appears on m_data_o after edge N) and sustain 1 word/cycle while m_ready_i stays high.
REQ-020 SHALL preserve order and lose or duplicate no word under any s_valid_i/m_ready_i pattern.
REQ-021 SHALL hold m_data_o stable while m_valid_o && !m_ready_i.
REQ-022 SHALL ignore s_data_i when s_valid_i is low, and SHALL ignore m_ready_i in EMPTY.
REQ-023 SHALL have no combinational path from any input to any output.

Reset
REQ-024 SHALL, while rst_i is high, asynchronously force state to EMPTY, m_valid_o to 0, s_ready_o to 0 and stall_cnt_o to 0.
REQ-025 SHALL clear m_data_o and skid to 0 on reset.
REQ-026 SHALL drive s_ready_o to 1 on the first rising edge after rst_i is released.
REQ-027 SHALL discard any buffered words if reset is asserted mid-operation; no partial transfer completes.

Configuration
REQ-028 SHALL compile the stall counter only when macro SKID_BUFFER_STATS_EN is defined.
REQ-029 SHALL, with the macro, increment stall_cnt_o on every edge where m_valid_o && !m_ready_i, saturating at 16'hFFFF; reset clears it.
REQ-030 SHALL, without the macro, omit port stall_cnt_o and the counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL test reset release: after rst_i goes high then low -> m_valid_o=0, and s_ready_o=1 after one edge.
REQ-032 SHALL test streaming: m_ready_i=1, send 0x01..0x10 back-to-back -> same sequence out, one per cycle, 1-cycle latency, s_ready_o constantly 1.
REQ-033 SHALL test backpressure: send 0xA1,0xA2 with m_ready_i=0 -> FULL, s_ready_o=0, m_data_o=0xA1 held; raise m_ready_i -> 0xA1 then 0xA2 out, s_ready_o back to 1.
REQ-034 SHALL test random traffic: randomized s_valid_i/m_ready_i over 10000 words -> scoreboard shows exact order, no loss or duplication.
REQ-035 SHALL test reset mid-operation: assert rst_i in FULL -> m_valid_o=0 immediately; after release the old words never appear.
REQ-036 SHALL test stats (with SKID_BUFFER_STATS_EN): hold m_valid_o=1 with m_ready_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF with no wrap.
